// File: rtl/zapper_sense_pkg.sv
// Shared game package: screen-size defaults, field widths, aim FSM states
// and the pixel brightness helper.
`timescale 1ns/1ps
package zapper_sense_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned SUM_W   = 10;
  localparam int unsigned CNT_W   = 9;
  localparam int unsigned BOX_W   = 11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    SAMPLE,
    DONE
  } zs_state_e;

  // Zero-extended R+G+B; 3*255 fits in 10 bits.
  function automatic logic [SUM_W-1:0] luma_sum(input logic [COLOR_W-1:0] r,
                                                input logic [COLOR_W-1:0] g,
                                                input logic [COLOR_W-1:0] b);
    return SUM_W'(r) + SUM_W'(g) + SUM_W'(b);
  endfunction

endpackage

// File: rtl/zapper_sense_if.sv
// Light-gun sense bus: monitor-side video taps, trigger/aim in, result out.
//   master : video source / game logic (drives video, shot, aim)
//   slave  : zapper_sense (drives busy, hit_valid, hit, bright_cnt, sync_err)
`timescale 1ns/1ps
interface zapper_sense_if;
  import zapper_sense_pkg::*;

  logic               pix_en;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               VGA_BLANK_N;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;
  logic               shot;
  logic [COORD_W-1:0] aim_x;
  logic [COORD_W-1:0] aim_y;
  logic               busy;
  logic               hit_valid;
  logic               hit;
  logic [CNT_W-1:0]   bright_cnt;
  logic               sync_err;

  modport master (
    output pix_en, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
    output shot, aim_x, aim_y,
    input  busy, hit_valid, hit, bright_cnt, sync_err
  );

  modport slave (
    input  pix_en, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
    input  shot, aim_x, aim_y,
    output busy, hit_valid, hit, bright_cnt, sync_err
  );

endinterface

// File: rtl/zapper_sense_vga_pos_tracker.sv
// Recovers the current pixel position from the monitor-side VGA timing.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_pix_en            : one-clock pixel strobe
//   i_hs, i_vs          : active-low syncs
//   i_blank_n           : high during active video
//   o_x, o_y            : position of the pixel presented this cycle
//   o_active_c          : a pixel is presented this cycle
//   o_line_end_c        : HS falling edge
//   o_frame_start_c     : VS falling edge
//   o_sync_err          : sticky, a line with video had the wrong length
`timescale 1ns/1ps
module vga_pos_tracker
  import zapper_sense_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_en,
  input  logic               i_hs,
  input  logic               i_vs,
  input  logic               i_blank_n,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_active_c,
  output logic               o_line_end_c,
  output logic               o_frame_start_c,
  output logic               o_sync_err
);

  logic               r_hs;
  logic               r_vs;
  logic               r_blank_n;
  logic               r_line_act;
  logic               r_sync_err;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  logic w_hs_fall;
  logic w_vs_fall;
  logic w_active;

  assign w_hs_fall = r_hs & ~i_hs;
  assign w_vs_fall = r_vs & ~i_vs;
  assign w_active  = i_pix_en & i_blank_n;

  // Sync edge detect, pixel/line counters and line-length check.
  // r_blank_n resets low so a reset released in blanking cannot mark a
  // partial line as active.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
      r_blank_n  <= 1'b0;
      r_line_act <= 1'b0;
      r_sync_err <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      r_hs      <= i_hs;
      r_vs      <= i_vs;
      r_blank_n <= i_blank_n;

      if (w_hs_fall)        r_x <= '0;
      else if (w_active)    r_x <= r_x + COORD_W'(1);

      if (w_vs_fall)                      r_y <= '0;
      else if (w_hs_fall && r_line_act)   r_y <= r_y + COORD_W'(1);

      if (w_hs_fall)        r_line_act <= 1'b0;
      else if (r_blank_n)   r_line_act <= 1'b1;

      if (w_hs_fall && r_line_act && (r_x != COORD_W'(H_ACTIVE)))
        r_sync_err <= 1'b1;
    end
  end

  assign o_x             = r_x;
  assign o_y             = r_y;
  assign o_active_c      = w_active;
  assign o_line_end_c    = w_hs_fall;
  assign o_frame_start_c = w_vs_fall;
  assign o_sync_err      = r_sync_err;

endmodule

// File: rtl/zapper_sense.sv
// Light-gun (zapper) sensor: on a trigger, counts bright pixels inside a
// square aim box over one full frame and reports hit / bright count.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : zapper_sense_if.slave (video taps, shot/aim in, results out)
`timescale 1ns/1ps
module zapper_sense
  import zapper_sense_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned BOX_HALF = 8,
  parameter int unsigned LUMA_TH  = 600,
  parameter int unsigned HIT_TH   = 64
) (
  input  logic           Clk,
  input  logic           Reset,
  zapper_sense_if.slave  bus
);

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic               w_active;
  logic               w_line_end;
  logic               w_frame_start;
  logic               w_sync_err;

  vga_pos_tracker #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pos (
    .i_clk           (Clk),
    .i_rst           (Reset),
    .i_pix_en        (bus.pix_en),
    .i_hs            (bus.VGA_HS),
    .i_vs            (bus.VGA_VS),
    .i_blank_n       (bus.VGA_BLANK_N),
    .o_x             (w_x),
    .o_y             (w_y),
    .o_active_c      (w_active),
    .o_line_end_c    (w_line_end),
    .o_frame_start_c (w_frame_start),
    .o_sync_err      (w_sync_err)
  );

  zs_state_e          r_state;
  logic               r_busy;
  logic               r_hit_valid;
  logic               r_hit;
  logic [CNT_W-1:0]   r_bright_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [COORD_W-1:0] r_aim_x;
  logic [COORD_W-1:0] r_aim_y;

  zs_state_e          w_state_nxt;
  logic               w_busy_nxt;
  logic               w_hit_valid_nxt;
  logic               w_hit_nxt;
  logic [CNT_W-1:0]   w_bright_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [COORD_W-1:0] w_aim_x_nxt;
  logic [COORD_W-1:0] w_aim_y_nxt;

  // Box bounds in signed 11 bits so a box near the top/left edge clips at 0.
  logic signed [BOX_W-1:0] w_xs;
  logic signed [BOX_W-1:0] w_ys;
  logic signed [BOX_W-1:0] w_x_lo;
  logic signed [BOX_W-1:0] w_x_hi;
  logic signed [BOX_W-1:0] w_y_lo;
  logic signed [BOX_W-1:0] w_y_hi;
  logic                    w_in_box;
  logic                    w_on_screen;
  logic                    w_bright;
  logic                    w_count_en;

  assign w_xs   = $signed({1'b0, w_x});
  assign w_ys   = $signed({1'b0, w_y});
  assign w_x_lo = $signed({1'b0, r_aim_x}) - $signed(BOX_W'(BOX_HALF));
  assign w_x_hi = $signed({1'b0, r_aim_x}) + $signed(BOX_W'(BOX_HALF));
  assign w_y_lo = $signed({1'b0, r_aim_y}) - $signed(BOX_W'(BOX_HALF));
  assign w_y_hi = $signed({1'b0, r_aim_y}) + $signed(BOX_W'(BOX_HALF));

  assign w_in_box    = (w_xs >= w_x_lo) && (w_xs < w_x_hi) &&
                       (w_ys >= w_y_lo) && (w_ys < w_y_hi);
  assign w_on_screen = (w_x < COORD_W'(H_ACTIVE)) && (w_y < COORD_W'(V_ACTIVE));
  assign w_bright    = luma_sum(bus.VGA_R, bus.VGA_G, bus.VGA_B) >= SUM_W'(LUMA_TH);
  assign w_count_en  = w_active && w_on_screen && w_in_box && w_bright;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and next values of the registered outputs. The result is
  // loaded on the SAMPLE->DONE transition so it is visible during DONE.
  always_comb begin
    w_state_nxt      = r_state;
    w_busy_nxt       = r_busy;
    w_hit_valid_nxt  = 1'b0;
    w_hit_nxt        = r_hit;
    w_bright_cnt_nxt = r_bright_cnt;
    w_cnt_nxt        = r_cnt;
    w_aim_x_nxt      = r_aim_x;
    w_aim_y_nxt      = r_aim_y;

    unique case (r_state)
      IDLE: begin
        if (bus.shot) begin
          w_state_nxt = WAIT_FRAME;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_aim_x_nxt = bus.aim_x;
          w_aim_y_nxt = bus.aim_y;
        end
      end
      WAIT_FRAME: begin
        if (w_frame_start) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (w_count_en && (r_cnt != '1)) w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_frame_start) begin
          w_state_nxt      = DONE;
          w_hit_valid_nxt  = 1'b1;
          w_hit_nxt        = (w_cnt_nxt >= CNT_W'(HIT_TH));
          w_bright_cnt_nxt = w_cnt_nxt;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_busy       <= 1'b0;
      r_hit_valid  <= 1'b0;
      r_hit        <= 1'b0;
      r_bright_cnt <= '0;
      r_cnt        <= '0;
      r_aim_x      <= '0;
      r_aim_y      <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_hit_valid  <= w_hit_valid_nxt;
      r_hit        <= w_hit_nxt;
      r_bright_cnt <= w_bright_cnt_nxt;
      r_cnt        <= w_cnt_nxt;
      r_aim_x      <= w_aim_x_nxt;
      r_aim_y      <= w_aim_y_nxt;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.hit_valid  = r_hit_valid;
  assign bus.hit        = r_hit;
  assign bus.bright_cnt = r_bright_cnt;
  assign bus.sync_err   = w_sync_err;

endmodule

// File: tb/tb_zapper_sense.sv
// Directed bench for zapper_sense on a reduced 40x24 raster.
`timescale 1ns/1ps
module tb_zapper_sense;
  import zapper_sense_pkg::*;

  localparam int unsigned H       = 40;
  localparam int unsigned V       = 24;
  localparam int unsigned LINE_P  = H + 6;   // 2 front porch, 2 HS, 2 back porch
  localparam int unsigned FRAME_L = V + 3;   // VS low for line V+1
  localparam int unsigned FRAME_CLK = LINE_P * 2 * FRAME_L;

  logic Clk = 1'b0;
  logic Reset;

  zapper_sense_if bus ();

  zapper_sense #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .BOX_HALF (8),
    .LUMA_TH  (600),
    .HIT_TH   (64)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic       hit;
    logic [8:0] cnt;
    int         vs_idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_cmp = 0, n_fail = 0, n_pulses = 0, n_pushed = 0;
  int cyc = 0, vs_count = 0, vs_drop_cyc = 0;
  int gen_line = 0, gen_p = 0;
  int mode = 0, sq_x = 0, sq_y = 0;
  bit short_req = 1'b0;
  int short_done = 0;
  bit shot_vs_req = 1'b0, shot_vs_ack = 1'b0;
  int shot_vs_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix_rgb(input int x, input int y);
    logic [23:0] c;
    case (mode)
      0: c = 24'hFFFFFF;
      1: c = (x >= sq_x - 2 && x <= sq_x + 1 && y >= sq_y - 2 && y <= sq_y + 1) ?
             24'hFFFFFF : 24'h000000;
      default: c = (x % 2 == 0) ? {3{8'd200}} : {3{8'd199}};
    endcase
    return c;
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Video source: pix_en every other clock; white outside active pixels.
  initial begin : gen
    bit short_this;
    bit act, new_vs;
    logic [23:0] rgb;
    short_this      = 1'b0;
    bus.pix_en      = 1'b0;
    bus.VGA_HS      = 1'b1;
    bus.VGA_VS      = 1'b1;
    bus.VGA_BLANK_N = 1'b0;
    bus.VGA_R = 8'hFF; bus.VGA_G = 8'hFF; bus.VGA_B = 8'hFF;
    forever begin
      for (int l = 0; l < int'(FRAME_L); l++) begin
        for (int p = 0; p < int'(LINE_P); p++) begin
          for (int s = 0; s < 2; s++) begin
            @(posedge Clk); #1;
            gen_line = l; gen_p = p;
            if (p == 0 && s == 0 && l < int'(V) && short_req) begin
              short_this = 1'b1; short_req = 1'b0;
            end
            act = (l < int'(V)) && (p < int'(H)) && !(short_this && p == int'(H) - 1);
            bus.pix_en      = (s == 0);
            bus.VGA_BLANK_N = act;
            bus.VGA_HS      = !(p >= int'(H) + 2 && p < int'(H) + 4);
            new_vs          = !(l == int'(V) + 1);
            if (bus.VGA_VS && !new_vs) begin
              vs_count++;
              vs_drop_cyc = cyc;
              if (shot_vs_req) begin
                bus.shot = 1'b1; shot_vs_req = 1'b0;
                shot_vs_ack = 1'b1; shot_vs_idx = vs_count;
              end
            end
            bus.VGA_VS = new_vs;
            rgb = (act && s == 0) ? pix_rgb(p, l) : 24'hFFFFFF;
            bus.VGA_R = rgb[23:16]; bus.VGA_G = rgb[15:8]; bus.VGA_B = rgb[7:0];
            if (p == int'(LINE_P) - 1 && s == 1 && short_this) begin
              short_this = 1'b0; short_done++;
            end
          end
        end
      end
    end
  end

  // Scoreboard consumer.
  always @(negedge Clk) begin
    if (!Reset && bus.hit_valid === 1'b1) begin
      n_pulses++;
      if (sb.size() == 0) check("unexpected_hit_valid", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("hit", 32'(bus.hit), 32'(mon_e.hit));
        check("bright_cnt", 32'(bus.bright_cnt), 32'(mon_e.cnt));
        check("vs_index", vs_count, mon_e.vs_idx);
        check("latency", cyc - vs_drop_cyc, 1);
        check("busy_at_result", 32'(bus.busy), 1);
      end
    end
  end

  task automatic fire(input int ax, input int ay, input logic eh, input int ec);
    bus.aim_x = 10'(ax);
    bus.aim_y = 10'(ay);
    bus.shot  = 1'b1;
    sb.push_back('{hit: eh, cnt: 9'(ec), vs_idx: vs_count + 2});
    n_pushed++;
    repeat (3) @(negedge Clk);
    bus.shot = 1'b0;
  endtask

  task automatic wait_results();
    int n = 0;
    while (sb.size() != 0 && n < 4 * int'(FRAME_CLK)) begin
      @(negedge Clk); n++;
    end
    check("result_timeout", sb.size(), 0);
    @(negedge Clk);
  endtask

  task automatic wait_vs(input int target);
    int n = 0;
    while (vs_count < target && n < 3 * int'(FRAME_CLK)) begin
      @(negedge Clk); n++;
    end
    check("vs_timeout", 32'(vs_count >= target), 1);
  endtask

  task automatic wait_porch();
    int n = 0;
    while (gen_p != int'(H) && n < 2 * int'(LINE_P) + 4) begin
      @(negedge Clk); n++;
    end
    check("porch_timeout", 32'(gen_p == int'(H)), 1);
  endtask

  task automatic reset_in_porch(input bit chk);
    Reset = 1'b1;
    @(negedge Clk);
    if (chk) begin
      check("busy_after_reset", 32'(bus.busy), 0);
      check("hit_valid_after_reset", 32'(bus.hit_valid), 0);
    end
    wait_porch();
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  initial begin : stim
    int k, n;
    Reset = 1'b1;
    bus.shot = 1'b0; bus.aim_x = '0; bus.aim_y = '0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_hit_valid", 32'(bus.hit_valid), 0);
    check("rst_hit", 32'(bus.hit), 0);
    check("rst_bright_cnt", 32'(bus.bright_cnt), 0);
    check("rst_sync_err", 32'(bus.sync_err), 0);
    wait_porch();
    Reset = 1'b0;
    @(negedge Clk);

    // White screen, centred aim: full 16x16 box.
    mode = 0;
    fire(20, 12, 1'b1, 256);
    check("busy_after_shot", 32'(bus.busy), 1);
    wait_results();
    @(negedge Clk);
    check("busy_idle", 32'(bus.busy), 0);
    check("hit_held_1", 32'(bus.hit), 1);
    check("bright_held", 32'(bus.bright_cnt), 256);
    check("sync_err_clean", 32'(bus.sync_err), 0);

    // Black screen with 4x4 white square; aim moved after latching.
    mode = 1; sq_x = 20; sq_y = 12;
    fire(20, 12, 1'b0, 16);
    bus.aim_x = 10'd5; bus.aim_y = 10'd5;
    wait_results();
    check("hit_held_0", 32'(bus.hit), 0);

    // Top-left aim: box clipped to 8x8, exactly HIT_TH.
    mode = 0;
    fire(0, 0, 1'b1, 64);
    wait_results();

    // Luma threshold boundary: 200*3 bright, 199*3 not -> even columns only.
    mode = 2;
    fire(20, 12, 1'b1, 128);
    wait_results();

    // Second shot during SAMPLE is ignored.
    mode = 0;
    k = vs_count;
    fire(20, 12, 1'b1, 256);
    wait_vs(k + 1);
    repeat (300) @(negedge Clk);
    bus.aim_x = 10'd3; bus.aim_y = 10'd3; bus.shot = 1'b1;
    repeat (3) @(negedge Clk);
    bus.shot = 1'b0;
    wait_results();

    // Shot coinciding with a VS falling edge: sampling starts one VS later.
    bus.aim_x = 10'd20; bus.aim_y = 10'd12;
    shot_vs_req = 1'b1;
    n = 0;
    while (!shot_vs_ack && n < 2 * int'(FRAME_CLK)) begin
      @(negedge Clk); n++;
    end
    check("shot_vs_timeout", 32'(shot_vs_ack), 1);
    sb.push_back('{hit: 1'b1, cnt: 9'd256, vs_idx: shot_vs_idx + 2});
    n_pushed++;
    repeat (2) @(negedge Clk);
    bus.shot = 1'b0; shot_vs_ack = 1'b0;
    wait_results();

    // Reset during SAMPLE abandons the measurement.
    k = vs_count;
    bus.aim_x = 10'd20; bus.aim_y = 10'd12; bus.shot = 1'b1;
    repeat (3) @(negedge Clk);
    bus.shot = 1'b0;
    wait_vs(k + 1);
    repeat (200) @(negedge Clk);
    reset_in_porch(1'b1);
    check("hit_after_reset", 32'(bus.hit), 0);
    check("bright_after_reset", 32'(bus.bright_cnt), 0);
    wait_vs(k + 3);
    repeat (100) @(negedge Clk);
    fire(20, 12, 1'b1, 256);
    wait_results();
    check("sync_err_before_short", 32'(bus.sync_err), 0);

    // One 39-pixel line: sticky sync_err until reset.
    short_req = 1'b1;
    k = short_done;
    n = 0;
    while (short_done == k && n < 2 * int'(FRAME_CLK)) begin
      @(negedge Clk); n++;
    end
    check("short_line_timeout", 32'(short_done != k), 1);
    repeat (10) @(negedge Clk);
    check("sync_err_set", 32'(bus.sync_err), 1);
    repeat (FRAME_CLK) @(negedge Clk);
    check("sync_err_sticky", 32'(bus.sync_err), 1);
    reset_in_porch(1'b0);
    check("sync_err_cleared", 32'(bus.sync_err), 0);

    check("hit_valid_pulses", n_pulses, n_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
